exec_stage: RTL and testbench
=============================

# exec_stage

Y86-64 execute stage: accepts one decoded instruction per handshake, drives the combinational `alu` block (select/p/q in, r/ofw out) with the operands and function each icode requires, and registers valE. It owns the condition-code register (ZF/SF/OF) and computes Cnd for cmovXX/jXX. It sits between decode and memory as a single registered stage with valid/ready flow control on both sides.

## Interface
- No parameters; datapath fixed at 64 bits signed.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  stage can accept; `in_ready = ~out_valid | out_ready` (combinational).
- `icode`  in  4  Y86 instruction code.
- `ifun`  in  4  Y86 function code.
- `valA`, `valB`, `valC`  in  64 each  signed operands.
- `out_valid`  out  1  registered result valid.
- `out_ready`  in  1  memory stage takes the result.
- `valE`  out  64  registered ALU result.
- `cnd`  out  1  registered condition outcome.
- `err`  out  1  registered: invalid icode/ifun.
- `cc_zf`, `cc_sf`, `cc_of`  out  1 each  current CC register.

## Operation
- Accept = `in_valid & in_ready`. On accept, `valE`, `cnd`, `err` load and `out_valid` sets. On `out_valid & out_ready` without a new accept, `out_valid` clears.
- ALU select encoding: 00 AND, 01 XOR, 10 ADD, 11 SUB (SUB = p − q).
- Operand map (p, q, select):
  - OPq (6): p=valB, q=valA; ifun 0→10, 1→11, 2→00, 3→01; ifun>3 → err=1, valE=0.
  - rrmovq/cmovXX (2): valA, 0, ADD. irmovq (3): valC, 0, ADD.
  - rmmovq (4), mrmovq (5): valB, valC, ADD.
  - call (8), pushq (A): valB, −8, ADD. ret (9), popq (B): valB, +8, ADD.
  - halt (0), nop (1), jXX (7): valE=0.
  - icode C–F: err=1, valE=0, cnd=0, no CC update.
- Cnd (icode 2 and 7 only, else 0), from CC value *before* this instruction's edge: ifun 0 1; 1 (SF^OF)|ZF; 2 SF^OF; 3 ZF; 4 ~ZF; 5 ~(SF^OF); 6 ~(SF^OF)&~ZF; ifun>6 → cnd=0, err=1.
- CC update only on accept of icode 6 with ifun ≤ 3: ZF = (r==0), SF = r[63], OF = ofw. AND/XOR force OF=0.

## Timing
- Latency: 1 cycle accept→`out_valid`. Throughput 1/cycle when `out_ready`=1.
- Reset (async, any time, including mid-transfer): `out_valid`=0, `valE`=0, `cnd`=0, `err`=0, ZF=1, SF=0, OF=0; held instruction discarded. `in_ready`=1 during and after reset.
- Stall: while `out_valid & ~out_ready`, `in_ready`=0 and `valE`/`cnd`/`err` hold stable; CC does not change.
- Simultaneous drain and accept: new result loads, `out_valid` stays 1, no bubble.
- Back-to-back OPq then jXX/cmovXX: the second instruction's Cnd sees CC written by the first.
- Overflow wrap: ADD/SUB results wrap mod 2^64; only OF reports it.

## Test plan
- Reset then idle: `rst_n`=0 → valE=0, out_valid=0, ZF=1/SF=0/OF=0, in_ready=1.
- OPq add valA=1, valB=0x7FFF_FFFF_FFFF_FFFF → valE=0x8000_0000_0000_0000, OF=1, SF=1, ZF=0 one cycle later.
- OPq sub valA=5, valB=5, then jXX ifun 3 (je) next cycle → first valE=0, ZF=1; second cnd=1, valE=0.
- pushq valB=0x100 with `out_ready`=0 for 3 cycles → valE=0xF8 held, in_ready=0, next instruction accepted on the cycle out_ready rises.
- Invalid icode 0xE and OPq ifun 5 → err=1, valE=0, CC unchanged.
- Assert `rst_n` low while out_valid=1 and out_ready=0 → out_valid drops immediately (asynchronously), CC returns to ZF=1.

Source files
------------

// File: rtl/exec_stage_if.sv
// Handshake and payload bundle between decode, the execute stage and memory.
// The master side drives instructions in and result-ready; the slave side is the stage.
interface exec_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] valE;
    logic        cnd;
    logic        err;
    logic        cc_zf;
    logic        cc_sf;
    logic        cc_of;

    modport master (
        output in_valid, icode, ifun, valA, valB, valC, out_ready,
        input  in_ready, out_valid, valE, cnd, err, cc_zf, cc_sf, cc_of
    );

    modport slave (
        input  in_valid, icode, ifun, valA, valB, valC, out_ready,
        output in_ready, out_valid, valE, cnd, err, cc_zf, cc_sf, cc_of
    );
endinterface

// File: rtl/exec_stage.sv
// Y86-64 execute stage: operand steering into a combinational ALU, condition-code
// register, Cnd evaluation and a single registered valid/ready output slot.

module alu (
    input  logic [1:0]  select,
    input  logic [63:0] p,
    input  logic [63:0] q,
    output logic [63:0] r,
    output logic        ofw
);
    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_XOR = 2'b01;
    localparam logic [1:0] SEL_ADD = 2'b10;

    // Signed overflow: result sign disagrees with what the operand signs allow.
    always_comb begin
        r   = '0;
        ofw = 1'b0;
        case (select)
            SEL_AND: r = p & q;
            SEL_XOR: r = p ^ q;
            SEL_ADD: begin
                r   = p + q;
                ofw = (p[63] == q[63]) && (r[63] != p[63]);
            end
            default: begin
                r   = p - q;
                ofw = (p[63] != q[63]) && (r[63] != p[63]);
            end
        endcase
    end
endmodule

module exec_stage (
    input  logic         clk,
    input  logic         rst_n,
    exec_stage_if.slave  bus
);
    localparam int unsigned XLEN = 64;

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_XOR = 2'b01;
    localparam logic [1:0] SEL_ADD = 2'b10;
    localparam logic [1:0] SEL_SUB = 2'b11;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [XLEN-1:0] STACK_STEP = XLEN'(8);

    logic [1:0]      alu_sel;
    logic [XLEN-1:0] alu_p;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] alu_r;
    logic            alu_ofw;

    logic            cond_c;
    logic            cond_bad_c;
    logic            zero_res_c;
    logic            err_c;
    logic            cnd_c;
    logic            cc_we_c;
    logic            accept_c;
    logic [XLEN-1:0] vale_c;

    logic            out_valid_q;
    logic [XLEN-1:0] vale_q;
    logic            cnd_q;
    logic            err_q;
    logic            zf_q;
    logic            sf_q;
    logic            of_q;

    alu u_alu (
        .select (alu_sel),
        .p      (alu_p),
        .q      (alu_q),
        .r      (alu_r),
        .ofw    (alu_ofw)
    );

    // Branch/move condition, evaluated against the CC value held before this edge.
    always_comb begin
        cond_c     = 1'b0;
        cond_bad_c = 1'b0;
        case (bus.ifun)
            4'd0:    cond_c = 1'b1;
            4'd1:    cond_c = (sf_q ^ of_q) | zf_q;
            4'd2:    cond_c = sf_q ^ of_q;
            4'd3:    cond_c = zf_q;
            4'd4:    cond_c = ~zf_q;
            4'd5:    cond_c = ~(sf_q ^ of_q);
            4'd6:    cond_c = ~(sf_q ^ of_q) & ~zf_q;
            default: cond_bad_c = 1'b1;
        endcase
    end

    // Per-icode operand steering, ALU function and error/CC-write qualification.
    always_comb begin
        alu_sel    = SEL_ADD;
        alu_p      = '0;
        alu_q      = '0;
        zero_res_c = 1'b0;
        err_c      = 1'b0;
        cnd_c      = 1'b0;
        cc_we_c    = 1'b0;
        case (bus.icode)
            I_HALT, I_NOP: zero_res_c = 1'b1;
            I_RRMOVQ: begin
                alu_p      = bus.valA;
                cnd_c      = cond_c;
                err_c      = cond_bad_c;
                zero_res_c = cond_bad_c;
            end
            I_IRMOVQ: alu_p = bus.valC;
            I_RMMOVQ, I_MRMOVQ: begin
                alu_p = bus.valB;
                alu_q = bus.valC;
            end
            I_OPQ: begin
                alu_p = bus.valB;
                alu_q = bus.valA;
                case (bus.ifun)
                    4'd0: begin alu_sel = SEL_ADD; cc_we_c = 1'b1; end
                    4'd1: begin alu_sel = SEL_SUB; cc_we_c = 1'b1; end
                    4'd2: begin alu_sel = SEL_AND; cc_we_c = 1'b1; end
                    4'd3: begin alu_sel = SEL_XOR; cc_we_c = 1'b1; end
                    default: begin
                        err_c      = 1'b1;
                        zero_res_c = 1'b1;
                    end
                endcase
            end
            I_JXX: begin
                zero_res_c = 1'b1;
                cnd_c      = cond_c;
                err_c      = cond_bad_c;
            end
            I_CALL, I_PUSHQ: begin
                alu_p = bus.valB;
                alu_q = '0 - STACK_STEP;
            end
            I_RET, I_POPQ: begin
                alu_p = bus.valB;
                alu_q = STACK_STEP;
            end
            default: begin
                err_c      = 1'b1;
                zero_res_c = 1'b1;
            end
        endcase
    end

    assign vale_c       = zero_res_c ? '0 : alu_r;
    assign bus.in_ready = ~out_valid_q | bus.out_ready;
    assign accept_c     = bus.in_valid & bus.in_ready;

    // Output slot: load on accept, empty on drain without a replacement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            vale_q      <= '0;
            cnd_q       <= 1'b0;
            err_q       <= 1'b0;
        end else if (accept_c) begin
            out_valid_q <= 1'b1;
            vale_q      <= vale_c;
            cnd_q       <= cnd_c;
            err_q       <= err_c;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Condition codes; reset value reflects a zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (accept_c && cc_we_c) begin
            zf_q <= (alu_r == '0);
            sf_q <= alu_r[XLEN-1];
            of_q <= alu_ofw;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.valE      = vale_q;
    assign bus.cnd       = cnd_q;
    assign bus.err       = err_q;
    assign bus.cc_zf     = zf_q;
    assign bus.cc_sf     = sf_q;
    assign bus.cc_of     = of_q;
endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: vector table through a result scoreboard, then hand-written
// stall and asynchronous-reset sequences.
module tb_exec_stage;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    exec_stage_if bus ();

    exec_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [63:0] e_vale;
        logic        e_cnd;
        logic        e_err;
        logic        e_zf;
        logic        e_sf;
        logic        e_of;
    } vec_t;

    typedef struct {
        logic [63:0] vale;
        logic        cnd;
        logic        err;
        logic        zf;
        logic        sf;
        logic        of;
    } exp_t;

    localparam int NV = 26;

    vec_t vecs [NV];
    exp_t sb [$];
    exp_t cur_exp;
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: retire on output transfer, enqueue on input accept.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: valE 0x%h with empty scoreboard", bus.valE);
                end else begin
                    mon_e = sb.pop_front();
                    check64("sb_valE", bus.valE, mon_e.vale);
                    check1("sb_cnd", bus.cnd, mon_e.cnd);
                    check1("sb_err", bus.err, mon_e.err);
                    check1("sb_zf", bus.cc_zf, mon_e.zf);
                    check1("sb_sf", bus.cc_sf, mon_e.sf);
                    check1("sb_of", bus.cc_of, mon_e.of);
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(cur_exp);
        end
    end

    task automatic drive(input vec_t v);
        bus.icode    = v.icode;
        bus.ifun     = v.ifun;
        bus.valA     = v.a;
        bus.valB     = v.b;
        bus.valC     = v.c;
        bus.in_valid = 1'b1;
        cur_exp      = '{v.e_vale, v.e_cnd, v.e_err, v.e_zf, v.e_sf, v.e_of};
    endtask

    // Present one instruction until accepted; optionally randomise out_ready each cycle.
    task automatic send(input vec_t v, input bit stall);
        bit acc;
        acc = 1'b0;
        drive(v);
        for (int cyc = 0; cyc < 50 && !acc; cyc++) begin
            bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: icode %h never accepted", v.icode);
        end
    endtask

    task automatic idle_drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic vec_t mk(input logic [3:0] icode, input logic [3:0] ifun,
                                input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                                input logic [63:0] ev, input logic ec, input logic ee,
                                input logic ez, input logic es, input logic eo);
        vec_t v;
        v = '{icode, ifun, a, b, c, ev, ec, ee, ez, es, eo};
        return v;
    endfunction

    vec_t hv;

    initial begin
        vecs[0]  = mk(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000, 0, 0, 0, 1, 1);
        vecs[1]  = mk(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 64'd0, 0, 0, 0, 1, 1);
        vecs[2]  = mk(4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 64'd0, 1, 0, 0, 1, 1);
        vecs[3]  = mk(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 64'd0, 0, 0, 1, 0, 0);
        vecs[4]  = mk(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 64'd0, 1, 0, 1, 0, 0);
        vecs[5]  = mk(4'h2, 4'h4, 64'h1234, 64'd0, 64'd0, 64'h1234, 0, 0, 1, 0, 0);
        vecs[6]  = mk(4'h6, 4'h2, 64'hF0F0, 64'hFF00, 64'd0, 64'hF000, 0, 0, 0, 0, 0);
        vecs[7]  = mk(4'h6, 4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 1, 0);
        vecs[8]  = mk(4'h2, 4'h2, 64'hABC, 64'd0, 64'd0, 64'hABC, 1, 0, 0, 1, 0);
        vecs[9]  = mk(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 1);
        vecs[10] = mk(4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 64'd0, 0, 0, 0, 0, 1);
        vecs[11] = mk(4'h3, 4'h0, 64'd0, 64'd0, 64'hDEAD, 64'hDEAD, 0, 0, 0, 0, 1);
        vecs[12] = mk(4'h4, 4'h0, 64'd0, 64'h1000, 64'h20, 64'h1020, 0, 0, 0, 0, 1);
        vecs[13] = mk(4'h5, 4'h0, 64'd0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1FF8, 0, 0, 0, 0, 1);
        vecs[14] = mk(4'h8, 4'h0, 64'd0, 64'h100, 64'd0, 64'hF8, 0, 0, 0, 0, 1);
        vecs[15] = mk(4'h9, 4'h0, 64'd0, 64'h100, 64'd0, 64'h108, 0, 0, 0, 0, 1);
        vecs[16] = mk(4'hB, 4'h0, 64'd0, 64'h50, 64'd0, 64'h58, 0, 0, 0, 0, 1);
        vecs[17] = mk(4'hA, 4'h0, 64'd0, 64'h200, 64'd0, 64'h1F8, 0, 0, 0, 0, 1);
        vecs[18] = mk(4'h0, 4'h0, 64'd5, 64'd6, 64'd7, 64'd0, 0, 0, 0, 0, 1);
        vecs[19] = mk(4'h1, 4'h0, 64'd5, 64'd6, 64'd7, 64'd0, 0, 0, 0, 0, 1);
        vecs[20] = mk(4'hE, 4'h0, 64'd1, 64'd2, 64'd3, 64'd0, 0, 1, 0, 0, 1);
        vecs[21] = mk(4'h6, 4'h5, 64'd3, 64'd4, 64'd0, 64'd0, 0, 1, 0, 0, 1);
        vecs[22] = mk(4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 64'd0, 0, 1, 0, 0, 1);
        vecs[23] = mk(4'h7, 4'h0, 64'd0, 64'd0, 64'd0, 64'd0, 1, 0, 0, 0, 1);
        vecs[24] = mk(4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 64'd0, 1, 0, 0, 0, 1);
        vecs[25] = mk(4'h6, 4'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 0, 0, 1, 0, 1);

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.icode     = '0;
        bus.ifun      = '0;
        bus.valA      = '0;
        bus.valB      = '0;
        bus.valC      = '0;
        cur_exp       = '{64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state, sampled while reset is still asserted.
        #12;
        check1("rst_out_valid", bus.out_valid, 1'b0);
        check64("rst_valE", bus.valE, 64'd0);
        check1("rst_cnd", bus.cnd, 1'b0);
        check1("rst_err", bus.err, 1'b0);
        check1("rst_zf", bus.cc_zf, 1'b1);
        check1("rst_sf", bus.cc_sf, 1'b0);
        check1("rst_of", bus.cc_of, 1'b0);
        check1("rst_in_ready", bus.in_ready, 1'b1);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check1("idle_out_valid", bus.out_valid, 1'b0);
        check1("idle_in_ready", bus.in_ready, 1'b1);

        // Full-throughput pass, then a pass with random output back-pressure.
        for (int i = 0; i < NV; i++) send(vecs[i], 1'b0);
        idle_drain();
        for (int i = 0; i < NV; i++) send(vecs[i], 1'b1);
        idle_drain();
        check1("drain_out_valid", bus.out_valid, 1'b0);

        // pushq held through three stalled cycles; follower accepted as out_ready rises.
        bus.out_ready = 1'b0;
        hv = mk(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 64'hF8, 0, 0, 1, 0, 1);
        drive(hv);
        @(posedge clk);
        #1;
        hv = mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 64'd0, 0, 0, 1, 0, 1);
        drive(hv);
        for (int k = 0; k < 3; k++) begin
            check1("stall_out_valid", bus.out_valid, 1'b1);
            check64("stall_valE", bus.valE, 64'hF8);
            check1("stall_in_ready", bus.in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        #1;
        check1("release_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check1("follow_out_valid", bus.out_valid, 1'b1);
        check64("follow_valE", bus.valE, 64'd0);
        idle_drain();

        // Asynchronous reset while a result is stalled in the slot.
        bus.out_ready = 1'b0;
        hv = mk(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000, 0, 0, 0, 1, 1);
        drive(hv);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check1("pre_rst_out_valid", bus.out_valid, 1'b1);
        check1("pre_rst_zf", bus.cc_zf, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check1("async_rst_out_valid", bus.out_valid, 1'b0);
        check64("async_rst_valE", bus.valE, 64'd0);
        check1("async_rst_zf", bus.cc_zf, 1'b1);
        check1("async_rst_sf", bus.cc_sf, 1'b0);
        check1("async_rst_of", bus.cc_of, 1'b0);
        check1("async_rst_in_ready", bus.in_ready, 1'b1);
        sb.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle_drain();

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_empty: %0d results never produced, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
